// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares the single bus master between instruction fetch (IF)
// and data (D) requesters. One transaction at a time, D has priority with a
// starvation guard for IF. Misaligned and reserved-size requests are rejected
// without a bus cycle, and a bus cycle with no bus_ack is aborted after a timeout.
module rv_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned STARVE_MAX     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_tsize,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_tsize,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner_d, owner_d_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic          pick_d;
  logic [31:0]   pick_addr;
  logic [1:0]    pick_tsize;
  logic          pick_bad;

  logic          bus_req_nxt, bus_wr_nxt;
  logic [31:0]   bus_addr_nxt, bus_wdata_nxt;
  logic [1:0]    bus_tsize_nxt;
  logic          if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
  logic [31:0]   if_rdata_nxt, d_rdata_nxt;

  // Winner selection and alignment check of the winner's request
  always_comb begin
    pick_d     = d_req && !(if_req && (streak == STREAK_MAX));
    pick_addr  = pick_d ? d_addr : if_addr;
    pick_tsize = pick_d ? d_tsize : 2'b10;
    case (pick_tsize)
      2'b00:   pick_bad = 1'b0;
      2'b01:   pick_bad = pick_addr[0];
      2'b10:   pick_bad = |pick_addr[1:0];
      default: pick_bad = 1'b1;
    endcase
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    streak_nxt    = if_req ? streak : '0;
    timer_nxt     = timer;
    bus_req_nxt   = bus_req;
    bus_wr_nxt    = bus_wr;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_tsize_nxt = bus_tsize;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ack_nxt    = 1'b0;
    if_err_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    d_err_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          owner_d_nxt = pick_d;
          if (pick_d && if_req)
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + SW'(1);
          else
            streak_nxt = '0;
          if (pick_bad) begin
            state_nxt  = S_DONE;
            if_ack_nxt = !pick_d;
            if_err_nxt = !pick_d;
            d_ack_nxt  = pick_d;
            d_err_nxt  = pick_d;
          end else begin
            state_nxt     = S_BUSY;
            timer_nxt     = '0;
            bus_req_nxt   = 1'b1;
            bus_wr_nxt    = pick_d && d_wr;
            bus_addr_nxt  = pick_addr;
            bus_wdata_nxt = pick_d ? d_wdata : '0;
            bus_tsize_nxt = pick_tsize;
          end
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          state_nxt   = S_DONE;
          bus_req_nxt = 1'b0;
          bus_wr_nxt  = 1'b0;
          if (owner_d) d_rdata_nxt = bus_rdata;
          else         if_rdata_nxt = bus_rdata;
          d_ack_nxt  = owner_d;
          if_ack_nxt = !owner_d;
        end else if (timer == TIMER_LAST) begin
          state_nxt   = S_DONE;
          bus_req_nxt = 1'b0;
          bus_wr_nxt  = 1'b0;
          d_ack_nxt   = owner_d;
          d_err_nxt   = owner_d;
          if_ack_nxt  = !owner_d;
          if_err_nxt  = !owner_d;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, ownership, starvation streak and timeout timer
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b0;
      streak    <= '0;
      timer     <= '0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_tsize <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      owner_d   <= owner_d_nxt;
      streak    <= streak_nxt;
      timer     <= timer_nxt;
      bus_req   <= bus_req_nxt;
      bus_wr    <= bus_wr_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
      bus_tsize <= bus_tsize_nxt;
      if_ack    <= if_ack_nxt;
      if_err    <= if_err_nxt;
      if_rdata  <= if_rdata_nxt;
      d_ack     <= d_ack_nxt;
      d_err     <= d_err_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

endmodule
